rr_stream_arbiter: RTL

Round-robin arbiter that shares one registered valid/ready output stage between N_REQ upstream streams. Grants are packet-granular: once a requester wins, it keeps the output until its `i_last` beat is accepted. The arbiter sits in front of a single downstream consumer in the datapath. Its output side is a two-register skid stage, so `o_ready` never depends combinationally on `i_ready`.

---
 rtl/stream_arb_pkg.sv | 32 +++
 rtl/skid_stage.sv | 61 ++++++
 rtl/rr_stream_arbiter.sv | 100 ++++++++++
 3 files changed

// File: rtl/stream_arb_pkg.sv
// stream_arb_pkg: shared types and helpers for rr_stream_arbiter.
//   st_t     - arbiter state (IDLE waits for a request, LOCKED owns the output)
//   rr_pick  - round-robin winner search starting at a priority pointer
package stream_arb_pkg;

    // Upper bound on requesters; rr_pick works on vectors of this width.
    localparam int MAX_REQ = 16;

    typedef enum logic {IDLE, LOCKED} st_t;

    // Returns the first set bit of req[n-1:0] scanning ptr, ptr+1, ... mod n.
    // Returns 0 when no bit is set (callers only use it with a request present).
    function automatic logic [3:0] rr_pick(input logic [MAX_REQ-1:0] req,
                                           input logic [3:0]         ptr,
                                           input int                 n);
        logic [3:0] win;
        logic       found;
        int         idx;
        win   = '0;
        found = 1'b0;
        for (int i = 0; i < MAX_REQ; i++) begin
            idx = int'(ptr) + i;
            if (idx >= n) idx = idx - n;
            if (i < n && !found && idx < MAX_REQ && req[idx]) begin
                win   = 4'(idx);
                found = 1'b1;
            end
        end
        return win;
    endfunction

endpackage

// File: rtl/skid_stage.sv
// skid_stage: registered valid/ready stage with a one-entry skid buffer.
// o_ready depends only on local registers, never on i_ready.
// Ports:
//   i_clk, i_reset_n     clock, async active-low reset
//   i_valid, o_ready     upstream handshake (o_ready = skid empty)
//   i_data [PW]          upstream payload
//   o_valid, o_data      registered downstream beat
//   i_ready              downstream ready
module skid_stage #(
    parameter int PW = 8
) (
    input  logic          i_clk,
    input  logic          i_reset_n,
    input  logic          i_valid,
    output logic          o_ready,
    input  logic [PW-1:0] i_data,
    output logic          o_valid,
    output logic [PW-1:0] o_data,
    input  logic          i_ready
);

    logic          r_valid_q;
    logic [PW-1:0] r_data_q;
    logic          acc;
    logic          out_ld;

    assign o_ready = !r_valid_q;
    assign acc     = i_valid && o_ready;
    assign out_ld  = !o_valid || i_ready;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            o_valid   <= 1'b0;
            o_data    <= '0;
            r_valid_q <= 1'b0;
            r_data_q  <= '0;
        end else begin
            // Output register: skid beat is older, so it always goes first.
            if (out_ld) begin
                if (r_valid_q) begin
                    o_valid <= 1'b1;
                    o_data  <= r_data_q;
                end else if (acc) begin
                    o_valid <= 1'b1;
                    o_data  <= i_data;
                end else begin
                    o_valid <= 1'b0;
                end
            end
            // A new beat lands in the skid when the output cannot take it:
            // either the output is stalled, or it is taking the skid beat.
            if (acc && (!out_ld || r_valid_q)) begin
                r_valid_q <= 1'b1;
                r_data_q  <= i_data;
            end else if (out_ld && r_valid_q) begin
                r_valid_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/rr_stream_arbiter.sv
// rr_stream_arbiter: packet-granular round-robin arbiter sharing one
// registered skid output stage between N_REQ valid/ready streams.
// Ports:
//   i_clk, i_reset_n   clock, async active-low reset
//   i_valid [N_REQ]    per-requester valid
//   i_data [N_REQ*DW]  requester k at [k*DW +: DW]
//   i_last [N_REQ]     per-requester end of packet
//   o_ready [N_REQ]    per-requester ready (from registers only)
//   o_valid/o_data/o_last/o_src  output beat and its source index
//   i_ready            downstream ready
module rr_stream_arbiter
    import stream_arb_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int DW    = 8,
    parameter int SW    = $clog2(N_REQ)
) (
    input  logic               i_clk,
    input  logic               i_reset_n,
    input  logic [N_REQ-1:0]   i_valid,
    input  logic [N_REQ*DW-1:0] i_data,
    input  logic [N_REQ-1:0]   i_last,
    output logic [N_REQ-1:0]   o_ready,
    output logic               o_valid,
    output logic [DW-1:0]      o_data,
    output logic               o_last,
    output logic [SW-1:0]      o_src,
    input  logic               i_ready
);

    localparam int PW = DW + 1 + SW;

    st_t           st_q;
    logic [SW-1:0] grant_q;
    logic [SW-1:0] ptr_q;
    logic [SW-1:0] ptr_d;

    logic          sel_valid;
    logic          sel_last;
    logic [DW-1:0] sel_data;
    logic          skid_rdy;
    logic          acc;
    logic [3:0]    pick;
    logic [PW-1:0] out_pl;

    // Grant mux: only the locked requester is presented to the stage.
    assign sel_valid = (st_q == LOCKED) && i_valid[grant_q];
    assign sel_data  = i_data[grant_q*DW +: DW];
    assign sel_last  = i_last[grant_q];
    assign acc       = sel_valid && skid_rdy;

    assign pick  = rr_pick(MAX_REQ'(i_valid), 4'(ptr_q), N_REQ);
    assign ptr_d = (grant_q == SW'(N_REQ - 1)) ? '0 : grant_q + 1'b1;

    // o_ready demux.
    always_comb begin
        o_ready = '0;
        if (st_q == LOCKED) o_ready[grant_q] = skid_rdy;
    end

    // Grant is held until the last beat is accepted, even if the owner
    // drops i_valid mid-packet.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            st_q    <= IDLE;
            grant_q <= '0;
            ptr_q   <= '0;
        end else begin
            case (st_q)
                IDLE: begin
                    if (|i_valid) begin
                        grant_q <= pick[SW-1:0];
                        st_q    <= LOCKED;
                    end
                end
                LOCKED: begin
                    if (acc && sel_last) begin
                        st_q  <= IDLE;
                        ptr_q <= ptr_d;
                    end
                end
                default: st_q <= IDLE;
            endcase
        end
    end

    skid_stage #(.PW(PW)) u_skid (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .i_valid   (sel_valid),
        .o_ready   (skid_rdy),
        .i_data    ({sel_last, grant_q, sel_data}),
        .o_valid   (o_valid),
        .o_data    (out_pl),
        .i_ready   (i_ready)
    );

    assign {o_last, o_src, o_data} = out_pl;

endmodule
